// File: rtl/successive_clap_counter.sv
// Groups single-cycle clap pulses into bursts and emits each burst length as one valid/ready transfer.
// Optional echo rejection: define SUCCLAP_REFRACTORY_EN to ignore claps arriving too soon after the previous one.
module successive_clap_counter #(
    parameter int unsigned SUC_CLAPS_WIDTH    = 16,
    parameter int unsigned TIMER_WIDTH        = 32,
    parameter int unsigned GAP_TIMEOUT_CYCLES = 25000000,
    parameter int unsigned REFRACTORY_CYCLES  = 2500000
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       clap_det,
    output logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
    output logic                       suc_claps_valid,
    input  logic                       suc_claps_ready
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        OUTPUT
    } state_t;

    localparam logic [TIMER_WIDTH-1:0]     TIMER_LAST = TIMER_WIDTH'(GAP_TIMEOUT_CYCLES - 1);
    localparam logic [SUC_CLAPS_WIDTH-1:0] COUNT_MAX  = '1;

    // Reject parameter sets where the gap could never outlast the refractory window.
    if (GAP_TIMEOUT_CYCLES < 2 || GAP_TIMEOUT_CYCLES <= REFRACTORY_CYCLES) begin : g_param_check
        $error("successive_clap_counter: GAP_TIMEOUT_CYCLES must be >= 2 and > REFRACTORY_CYCLES");
    end

    state_t                     state, state_nxt;
    logic [SUC_CLAPS_WIDTH-1:0] count, count_nxt;
    logic [TIMER_WIDTH-1:0]     timer, timer_nxt;
    logic [SUC_CLAPS_WIDTH-1:0] data_nxt;
    logic                       valid_nxt;
    logic                       clap_accept;

`ifdef SUCCLAP_REFRACTORY_EN
    // Pulses inside the refractory window are treated as echoes and leave the timer running.
    assign clap_accept = clap_det && (timer >= TIMER_WIDTH'(REFRACTORY_CYCLES));
`else
    assign clap_accept = clap_det;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state           <= IDLE;
            count           <= '0;
            timer           <= '0;
            suc_claps_data  <= '0;
            suc_claps_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            count           <= count_nxt;
            timer           <= timer_nxt;
            suc_claps_data  <= data_nxt;
            suc_claps_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        timer_nxt = timer;
        data_nxt  = suc_claps_data;
        valid_nxt = suc_claps_valid;

        case (state)
            IDLE: begin
                if (clap_det) begin
                    count_nxt = SUC_CLAPS_WIDTH'(1);
                    timer_nxt = '0;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                // A clap on the timeout edge extends the burst rather than closing it.
                if (clap_accept) begin
                    if (count != COUNT_MAX) begin
                        count_nxt = count + SUC_CLAPS_WIDTH'(1);
                    end
                    timer_nxt = '0;
                end else if (timer == TIMER_LAST) begin
                    data_nxt  = count;
                    valid_nxt = 1'b1;
                    state_nxt = OUTPUT;
                end else begin
                    timer_nxt = timer + TIMER_WIDTH'(1);
                end
            end
            OUTPUT: begin
                // Claps are dropped while the result waits for the consumer.
                if (suc_claps_valid && suc_claps_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = '0;
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/successive_clap_counter.md
Name: successive_clap_counter

Overview:
- Producer end of the successive-claps stream (suc_claps_data / suc_claps_valid / suc_claps_ready).
- Takes single-cycle clap-detect pulses from the audio front end and groups claps separated by less than a gap timeout into one burst.
- Emits the burst length as one valid/ready transfer toward the light-toggle consumer.

Parameters:
- SUC_CLAPS_WIDTH, 16: width of the burst count and of suc_claps_data.
- TIMER_WIDTH, 32: width of the inter-clap gap timer.
- GAP_TIMEOUT_CYCLES, 25000000: quiet cycles after the last accepted clap that close a burst. Must be ≥2 and > REFRACTORY_CYCLES.
- REFRACTORY_CYCLES, 2500000: minimum timer value at which a new clap is accepted (echo/bounce rejection). Used only with the optional feature.

Ports:
- clock, input, 1: single system clock, rising edge.
- nreset, input, 1: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clock externally.
- clap_det, input, 1: one-cycle pulse per detected clap, synchronous to clock.
- suc_claps_data, output, SUC_CLAPS_WIDTH: number of claps in the completed burst.
- suc_claps_valid, output, 1: burst count available.
- suc_claps_ready, input, 1: consumer accepts on an edge where valid and ready are both 1.

Behaviour:
- Reset values: suc_claps_valid=0, suc_claps_data=0. Internal count=0, timer=0, state=IDLE.
- FSM states: IDLE, COUNT, OUTPUT.
- IDLE:
  - clap_det=1 at edge E0 -> count<=1, timer<=0, state<=COUNT.
  - Otherwise hold.
- COUNT:
  - The timer increments by 1 each edge. After E0 it holds k at edge Ek. It saturates at GAP_TIMEOUT_CYCLES-1.
  - A clap is accepted when clap_det=1 and the acceptance rule passes (see Optional Feature). On acceptance: count<=count+1, saturating at 2^SUC_CLAPS_WIDTH-1 (never wraps); timer<=0.
  - Timeout: if timer==GAP_TIMEOUT_CYCLES-1 and no clap is accepted on that edge -> state<=OUTPUT, suc_claps_data<=count, suc_claps_valid<=1. valid therefore rises exactly GAP_TIMEOUT_CYCLES edges after the last accepted clap.
  - Clap on the timeout edge: the clap wins. Count increments and the state stays COUNT.
- OUTPUT:
  - suc_claps_valid and suc_claps_data are held stable until the handshake.
  - On the edge with valid&ready: valid<=0, count<=0, timer<=0, state<=IDLE. suc_claps_data keeps its last value.
  - clap_det is ignored for every cycle in OUTPUT, including the handshake edge. Those claps are dropped, not queued.
- Latency with ready tied high: valid is high for exactly one cycle, and IDLE is re-entered on the next edge.
- Reset mid-burst or mid-OUTPUT: the burst is discarded. valid drops asynchronously and no partial count is emitted.
- Back-pressure has no timeout: OUTPUT persists indefinitely while ready=0.

Optional Feature:
- Macro: SUCCLAP_REFRACTORY_EN.
- Defined: in COUNT, a clap is accepted only if the timer value before the edge is ≥ REFRACTORY_CYCLES. Earlier pulses are ignored and do not reset the timer.
- Undefined: every clap_det pulse in COUNT is accepted, REFRACTORY_CYCLES is unused, and no refractory comparator is built.
- IDLE acceptance is unconditional in both builds.

Test Plan:
All scenarios use SUC_CLAPS_WIDTH=4, GAP_TIMEOUT_CYCLES=20, REFRACTORY_CYCLES=4, suc_claps_ready=1 unless stated.
- Single clap at edge E0, no further claps -> valid=1 with data=1 after edge E20, for one cycle; then IDLE.
- Two claps 10 cycles apart -> one transfer with data=2, valid rising 20 edges after the second clap; data=1 is never emitted.
- Macro defined, claps at E0, E3 and E10 -> the E3 pulse is ignored and data=2. Macro undefined, same stimulus -> data=3.
- 17 claps spaced 8 cycles apart -> data=15 (saturated, no wrap).
- ready=0 for 30 cycles after valid rises, claps injected meanwhile -> valid and data stay stable and the claps are dropped. Raising ready completes one transfer, then the FSM returns to IDLE with count=0.
- nreset pulsed low mid-COUNT after 3 claps -> valid=0 immediately and no transfer occurs. A subsequent single clap yields data=1.
